// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the demux_deser serial-to-parallel block.
//   N_DEF     : default word width / bits per frame
//   idx_width : bit-index counter width derived from the word width
//   state_e   : frame-assembly FSM states
//   ERR_W     : width of the optional aborted-frame counter
package demux_pkg;

   localparam int unsigned N_DEF = 16;
   localparam int unsigned ERR_W = 8;

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StFull
   } state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/demux_idx_cnt.sv
// demux_idx_cnt: bit-index counter for frame assembly.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset (idx -> 0)
//   i_load1 : set idx to 1 (bit 0 was just written); wins over i_inc
//   i_inc   : advance idx; wraps to 0 after the terminal index
//   o_idx   : current bit index
//   o_last  : idx == N-1
module demux_idx_cnt #(
   parameter int unsigned N     = 16,
   parameter int unsigned IDX_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load1,
   input  logic             i_inc,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_last
);

   logic [IDX_W-1:0] r_idx;

   assign o_idx  = r_idx;
   assign o_last = (r_idx == IDX_W'(N - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_idx <= '0;
      end else if (i_load1) begin
         r_idx <= IDX_W'(1);
      end else if (i_inc) begin
         r_idx <= o_last ? '0 : r_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/demux_deser.sv
// demux_deser: receiving end of an N:1 bit mux. Collects N serial bits (LSB
// first, framed by i_s_first on bit 0) into a word presented on a
// valid/ready output with backpressure.
//   i_clk, i_rst_n            : clock, synchronous active-low reset
//   i_s_valid/i_s_bit/i_s_first/o_s_ready : serial input handshake
//   o_out/o_out_valid/i_out_ready        : assembled word output handshake
//   o_err_cnt                 : saturating aborted-frame count, only when
//                               DEMUX_DESER_ERRCNT_EN is defined
module demux_deser
   import demux_pkg::*;
#(
   parameter int unsigned N = N_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_s_valid,
   input  logic             i_s_bit,
   input  logic             i_s_first,
   output logic             o_s_ready,
   output logic [N-1:0]     o_out,
   output logic             o_out_valid,
   input  logic             i_out_ready
`ifdef DEMUX_DESER_ERRCNT_EN
   ,
   output logic [ERR_W-1:0] o_err_cnt
`endif
);

   localparam int unsigned IDX_W = idx_width(N);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [N-1:0]     r_asm;
   logic [N-1:0]     w_asm_nxt;
   logic [N-1:0]     r_out;
   logic [N-1:0]     w_out_nxt;
   logic             r_out_valid;
   logic             w_out_valid_nxt;
   logic             w_s_acc;
   logic             w_o_xfer;
   logic             w_load1;
   logic             w_inc;
   logic             w_abort;
   logic [IDX_W-1:0] w_idx;
   logic             w_last;

   assign o_s_ready   = (r_state != StFull);
   assign o_out       = r_out;
   assign o_out_valid = r_out_valid;
   assign w_s_acc     = i_s_valid && o_s_ready;
   assign w_o_xfer    = r_out_valid && i_out_ready;

   demux_idx_cnt #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_idx_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load1 (w_load1),
      .i_inc   (w_inc),
      .o_idx   (w_idx),
      .o_last  (w_last)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_asm_nxt       = r_asm;
      w_out_nxt       = r_out;
      w_out_valid_nxt = r_out_valid && !w_o_xfer;
      w_load1         = 1'b0;
      w_inc           = 1'b0;
      w_abort         = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_s_acc && i_s_first) begin
               w_asm_nxt[0] = i_s_bit;
               w_load1      = 1'b1;
               w_state_nxt  = StCollect;
            end
         end
         StCollect: begin
            if (w_s_acc) begin
               if (i_s_first) begin
                  // Restart: the partial frame is dropped, this bit is index 0.
                  w_asm_nxt[0] = i_s_bit;
                  w_load1      = 1'b1;
                  w_abort      = 1'b1;
               end else begin
                  w_asm_nxt[w_idx] = i_s_bit;
                  w_inc            = 1'b1;
                  if (w_last) begin
                     if (!r_out_valid || w_o_xfer) begin
                        w_out_nxt       = w_asm_nxt;
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = StIdle;
                     end else begin
                        w_state_nxt = StFull;
                     end
                  end
               end
            end
         end
         StFull: begin
            // out_valid is necessarily 1 here; the pending word replaces it.
            if (w_o_xfer) begin
               w_out_nxt       = r_asm;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_asm       <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_asm       <= w_asm_nxt;
         r_out       <= w_out_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

`ifdef DEMUX_DESER_ERRCNT_EN
   logic [ERR_W-1:0] r_err_cnt;

   assign o_err_cnt = r_err_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_err_cnt <= '0;
      end else if (w_abort && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
   end
`else
   logic w_unused;
   assign w_unused = w_abort;
`endif

endmodule

// File: tb/tb_demux_deser.sv
// tb_demux_deser: directed self-checking bench for demux_deser.
// Checks err_cnt only when DEMUX_DESER_ERRCNT_EN is defined.
module tb_demux_deser;

   logic        clk;
   logic        rst_n;
   logic        s_valid;
   logic        s_bit;
   logic        s_first;
   logic        s_ready;
   logic [15:0] out;
   logic        out_valid;
   logic        out_ready;
`ifdef DEMUX_DESER_ERRCNT_EN
   logic [7:0]  err_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   demux_deser #(
      .N (16)
   ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_s_valid   (s_valid),
      .i_s_bit     (s_bit),
      .i_s_first   (s_first),
      .o_s_ready   (s_ready),
      .o_out       (out),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready)
`ifdef DEMUX_DESER_ERRCNT_EN
      ,
      .o_err_cnt   (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are then stable.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic send(input logic b, input logic f);
      s_valid = 1'b1;
      s_bit   = b;
      s_first = f;
      tick();
      s_valid = 1'b0;
      s_first = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] w, input int lo, input int hi, input logic first0);
      for (int i = lo; i <= hi; i++) send(w[i], first0 && (i == lo));
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_out"}, 32'(out), 32'h0);
      check_eq({tag, "_valid"}, 32'(out_valid), 32'h0);
      check_eq({tag, "_s_ready"}, 32'(s_ready), 32'h1);
`ifdef DEMUX_DESER_ERRCNT_EN
      check_eq({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
`endif
   endtask

   initial begin
      rst_n     = 1'b0;
      s_valid   = 1'b0;
      s_bit     = 1'b0;
      s_first   = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check_reset_state("reset");

      // Basic frame
      out_ready = 1'b1;
      send_bits(16'hA5C3, 0, 14, 1'b1);
      check_eq("basic_no_early_valid", 32'(out_valid), 32'h0);
      send_bits(16'hA5C3, 15, 15, 1'b0);
      check_eq("basic_out", 32'(out), 32'hA5C3);
      check_eq("basic_valid", 32'(out_valid), 32'h1);
      tick();
      check_eq("basic_valid_one_cycle", 32'(out_valid), 32'h0);
      check_eq("basic_out_held", 32'(out), 32'hA5C3);

      // Framing: stray bits in IDLE are dropped
      for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
      check_eq("framing_discard", 32'(out_valid), 32'h0);
      send_bits(16'h0001, 0, 15, 1'b1);
      check_eq("framing_out", 32'(out), 32'h0001);
      check_eq("framing_valid", 32'(out_valid), 32'h1);
      tick();

      // Backpressure
      out_ready = 1'b0;
      send_bits(16'h1234, 0, 15, 1'b1);
      check_eq("bp_first_out", 32'(out), 32'h1234);
      check_eq("bp_first_valid", 32'(out_valid), 32'h1);
      check_eq("bp_first_s_ready", 32'(s_ready), 32'h1);
      send_bits(16'hFFFF, 0, 15, 1'b1);
      check_eq("bp_full_s_ready", 32'(s_ready), 32'h0);
      check_eq("bp_full_out_held", 32'(out), 32'h1234);
      s_valid = 1'b1;
      s_bit   = 1'b0;
      tick();
      check_eq("bp_full_s_ready_hold", 32'(s_ready), 32'h0);
      check_eq("bp_full_out_hold", 32'(out), 32'h1234);
      s_valid   = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("bp_release_out", 32'(out), 32'hFFFF);
      check_eq("bp_release_valid", 32'(out_valid), 32'h1);
      check_eq("bp_release_s_ready", 32'(s_ready), 32'h1);
      out_ready = 1'b1;
      tick();
      check_eq("bp_drain_valid", 32'(out_valid), 32'h0);

      // Abort at bit 9, then a full 0x8001 frame
      send_bits(16'h03FF, 0, 8, 1'b1);
      send_bits(16'h8001, 0, 15, 1'b1);
      check_eq("abort_out", 32'(out), 32'h8001);
      check_eq("abort_valid", 32'(out_valid), 32'h1);
`ifdef DEMUX_DESER_ERRCNT_EN
      check_eq("abort_err_cnt", 32'(err_cnt), 32'h1);
`endif
      tick();
      // 300 aborts: one frame start then 300 restarts
      send(1'b1, 1'b1);
      for (int i = 0; i < 300; i++) send(1'b1, 1'b1);
`ifdef DEMUX_DESER_ERRCNT_EN
      check_eq("abort_err_sat", 32'(err_cnt), 32'd255);
`endif
      check_eq("abort_no_word", 32'(out_valid), 32'h0);
      send_bits(16'h5A5A, 0, 15, 1'b1);
      check_eq("abort_after_out", 32'(out), 32'h5A5A);
      tick();

      // Reset in COLLECT at idx=7
      send_bits(16'h00FF, 0, 6, 1'b1);
      do_reset();
      check_reset_state("rst_collect");
      send_bits(16'hC3A5, 0, 15, 1'b1);
      check_eq("rst_collect_next_out", 32'(out), 32'hC3A5);
      check_eq("rst_collect_next_valid", 32'(out_valid), 32'h1);
      tick();

      // Reset in FULL
      out_ready = 1'b0;
      send_bits(16'h1111, 0, 15, 1'b1);
      send_bits(16'h2222, 0, 15, 1'b1);
      check_eq("rst_full_entered", 32'(s_ready), 32'h0);
      do_reset();
      check_reset_state("rst_full");
      out_ready = 1'b1;
      send_bits(16'hBEEF, 0, 15, 1'b1);
      check_eq("rst_full_next_out", 32'(out), 32'hBEEF);
      check_eq("rst_full_next_valid", 32'(out_valid), 32'h1);
      tick();
      check_eq("rst_full_next_drain", 32'(out_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
